draw_image: RTL and testbench

Reads a 128×128 sprite from an external synchronous image ROM and overlays it on the VGA timing/pixel stream at a run-time position. It sits in the VGA drawing pipeline between the background generator and the next draw stage. It drives the ROM address and consumes the ROM's 1-cycle-latency RGB word. All timing signals are re-aligned so sprite pixels land exactly on the matching hcount/vcount.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/delay.sv | 27 ++
 rtl/draw_image.sv | 117 +++++++++++
 tb/tb_draw_image.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA drawing-pipeline definitions: coordinate widths, sprite
// defaults, the transparent colour key and the packed timing/pixel bundle.
package vga_pkg;

  localparam int HCOUNT_W  = 11;
  localparam int POS_W     = 12;
  localparam int RGB_W     = 12;
  localparam int ADDR_W    = 14;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;

  localparam logic [RGB_W-1:0] TRANSP_KEY = 12'hF0F;

  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [HCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
    logic [RGB_W-1:0]    rgb;
  } vga_bus_t;

endpackage

// File: rtl/delay.sv
// Parametrised WIDTH x CLK_DEL shift register with synchronous reset.
// CLK_DEL must be at least 1.
module delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [CLK_DEL];

  // Shift the input through CLK_DEL register stages, clearing them on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[CLK_DEL-1];

endmodule

// File: rtl/draw_image.sv
// Overlays a sprite read from an external 1-cycle-latency ROM on the VGA
// stream. The sprite position is sampled once per frame at the start of
// vertical blanking, so it cannot tear. All outputs lag inputs by 3 clk.
module draw_image
  import vga_pkg::*;
#(
  parameter int                IMG_W      = IMG_W_DEF,
  parameter int                IMG_H      = IMG_H_DEF,
  parameter logic              TRANSP_EN  = 1'b1,
  parameter logic [RGB_W-1:0]  TRANSP_RGB = TRANSP_KEY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [POS_W-1:0]    xpos,
  input  logic [POS_W-1:0]    ypos,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [HCOUNT_W-1:0] vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblnk_in,
  input  logic                vblnk_in,
  input  logic [RGB_W-1:0]    rgb_in,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [RGB_W-1:0]    rom_rgb,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [HCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblnk_out,
  output logic                vblnk_out,
  output logic [RGB_W-1:0]    rgb_out
);

  logic [POS_W-1:0] xpos_q;
  logic [POS_W-1:0] ypos_q;
  logic             vblnk_prev;

  // Offsets are one bit wider than the position so negative results stay
  // negative instead of wrapping back into the sprite window.
  logic [POS_W:0]   relx;
  logic [POS_W:0]   rely;
  logic             in_win;
  logic             in_win_d1;
  logic             in_win_d2;

  vga_bus_t         bus_in;
  vga_bus_t         bus_d2;

  // Window test: offset non-negative and below the sprite size, not blanking.
  always_comb begin
    relx   = {2'b00, hcount_in} - {1'b0, xpos_q};
    rely   = {2'b00, vcount_in} - {1'b0, ypos_q};
    in_win = !relx[POS_W] && (relx < (POS_W+1)'(IMG_W)) &&
             !rely[POS_W] && (rely < (POS_W+1)'(IMG_H)) &&
             !hblnk_in && !vblnk_in;
  end

  // Stage 1: latch position on vblnk rising edge, register window flag and ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_q     <= '0;
      ypos_q     <= '0;
      vblnk_prev <= 1'b0;
      in_win_d1  <= 1'b0;
      rom_addr   <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        xpos_q <= xpos;
        ypos_q <= ypos;
      end
      in_win_d1 <= in_win;
      rom_addr  <= in_win ? {rely[6:0], relx[6:0]} : '0;
    end
  end

  assign bus_in = '{hcount: hcount_in, vcount: vcount_in,
                    hsync: hsync_in, vsync: vsync_in,
                    hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

  delay #(.WIDTH($bits(vga_bus_t)), .CLK_DEL(2)) u_bus_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (bus_in),
    .dout (bus_d2)
  );

  delay #(.WIDTH(1), .CLK_DEL(1)) u_win_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (in_win_d1),
    .dout (in_win_d2)
  );

  // Stage 3: composite the ROM pixel over the background and register all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= bus_d2.hcount;
      vcount_out <= bus_d2.vcount;
      hsync_out  <= bus_d2.hsync;
      vsync_out  <= bus_d2.vsync;
      hblnk_out  <= bus_d2.hblnk;
      vblnk_out  <= bus_d2.vblnk;
      rgb_out    <= (in_win_d2 && !(TRANSP_EN && (rom_rgb == TRANSP_RGB)))
                    ? rom_rgb : bus_d2.rgb;
    end
  end

endmodule

// File: tb/tb_draw_image.sv
// Randomised bench for draw_image: two instances (transparency on and off)
// share the stimulus; a frame-level reference model predicts every output.
module tb_draw_image;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos = '0, ypos = '0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;

  logic [13:0] rom_addr_a, rom_addr_b;
  logic [11:0] rom_rgb_a = '0, rom_rgb_b = '0;
  logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b;
  logic        hsync_a, vsync_a, hblnk_a, vblnk_a;
  logic        hsync_b, vsync_b, hblnk_b, vblnk_b;
  logic [11:0] rgb_a, rgb_b;

  typedef struct packed {
    logic [37:0] bus;
    logic [11:0] rgb2;
  } exp_t;

  exp_t        expQ[$];
  exp_t        e;
  int          asserts = 0;
  int          fails = 0;
  logic [11:0] mXpos, mYpos;
  logic        mVbPrev;
  logic [13:0] expAddr;

  always #5 clk = ~clk;

  draw_image #(.TRANSP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rom_addr(rom_addr_a), .rom_rgb(rom_rgb_a),
    .hcount_out(hcount_a), .vcount_out(vcount_a),
    .hsync_out(hsync_a), .vsync_out(vsync_a),
    .hblnk_out(hblnk_a), .vblnk_out(vblnk_a), .rgb_out(rgb_a)
  );

  draw_image #(.TRANSP_EN(1'b0)) dut_opaque (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .rom_addr(rom_addr_b), .rom_rgb(rom_rgb_b),
    .hcount_out(hcount_b), .vcount_out(vcount_b),
    .hsync_out(hsync_b), .vsync_out(vsync_b),
    .hblnk_out(hblnk_b), .vblnk_out(vblnk_b), .rgb_out(rgb_b)
  );

  // Sprite content: the address itself, except one planted key-coloured texel at (10,10).
  function automatic logic [11:0] romWord(input logic [13:0] a);
    if (a == 14'h050A) return 12'hF0F;
    return a[11:0];
  endfunction

  // Synchronous ROMs with one clock of read latency.
  always @(posedge clk) begin
    rom_rgb_a <= romWord(rom_addr_a);
    rom_rgb_b <= romWord(rom_addr_b);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the screen should show for the pixel sampled at this edge.
  task automatic modelStep();
    int   hx, vy, xp, yp, rx, ry;
    logic win;
    logic [13:0] a;
    logic [11:0] w;
    exp_t n;
    if (rst) begin
      expQ.delete();
      repeat (3) expQ.push_back('0);
      expAddr = '0;
      mXpos   = '0;
      mYpos   = '0;
      mVbPrev = 1'b0;
    end else begin
      hx = hcount_in; vy = vcount_in; xp = mXpos; yp = mYpos;
      rx = hx - xp;
      ry = vy - yp;
      win = (rx >= 0) && (rx < 128) && (ry >= 0) && (ry < 128) && !hblnk_in && !vblnk_in;
      a = win ? 14'(ry * 128 + rx) : 14'd0;
      w = romWord(a);
      n.bus  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
                (win && w != 12'hF0F) ? w : rgb_in};
      n.rgb2 = win ? w : rgb_in;
      expQ.push_back(n);
      expAddr = a;
      if (vblnk_in && !mVbPrev) begin
        mXpos = xpos;
        mYpos = ypos;
      end
      mVbPrev = vblnk_in;
    end
  endtask

  // One pixel clock: drive inputs, advance the model, check both DUTs.
  task automatic applyStimulus(input logic r, input int h, input int v, input logic [11:0] rgb);
    @(negedge clk);
    rst       = r;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = (h >= 800);
    hsync_in  = (h >= 840) && (h < 968);
    vblnk_in  = (v >= 600);
    vsync_in  = (v >= 601) && (v < 605);
    rgb_in    = rgb;
    @(posedge clk);
    modelStep();
    #1;
    e = expQ.pop_front();
    checkOutput("outputs", 64'({hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, rgb_a}), 64'(e.bus));
    checkOutput("rgb_opaque", 64'(rgb_b), 64'(e.rgb2));
    checkOutput("rom_addr", 64'(rom_addr_a), 64'(expAddr));
  endtask

  // Visible-area scan segment; the position inputs wander freely since no latch happens here.
  task automatic driveLine(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      xpos = 12'($urandom);
      ypos = 12'($urandom);
      applyStimulus(1'b0, h, v, 12'($urandom));
    end
  endtask

  // End of a visible frame followed by the start of vertical blanking.
  task automatic latchPos(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
    for (int h = 790; h < 800; h++) applyStimulus(1'b0, h, 599, 12'($urandom));
    for (int h = 0; h < 4; h++) applyStimulus(1'b0, h, 600, 12'($urandom));
  endtask

  initial begin
    int x, y;
    $display("[TB] draw_image randomised test starting");

    repeat (5) applyStimulus(1'b1, $urandom_range(0, 1055), $urandom_range(0, 627), 12'($urandom));
    applyStimulus(1'b0, 5, 0, 12'h123);
    driveLine(0, 6, 20);

    latchPos(2000, 2000);
    repeat (4) driveLine($urandom_range(0, 599), 0, 1055);

    latchPos(100, 50);
    driveLine(49, 90, 240);
    driveLine(50, 90, 240);
    driveLine(60, 90, 240);
    driveLine(80, 90, 240);
    driveLine(177, 90, 240);
    driveLine(178, 90, 240);

    latchPos(100, 50);
    driveLine(70, 90, 120);
    xpos = 12'd300;
    driveLine(70, 90, 450);
    latchPos(300, 50);
    driveLine(70, 280, 450);

    latchPos(750, 100);
    driveLine(100, 0, 1055);
    driveLine(150, 0, 1055);
    driveLine(227, 0, 1055);

    latchPos(4000, 4095);
    driveLine(10, 0, 1055);

    repeat (12) begin
      x = $urandom_range(0, 900);
      y = $urandom_range(0, 650);
      latchPos(x, y);
      driveLine((y + $urandom_range(0, 140)) % 600, 0, 1055);
    end

    latchPos(100, 50);
    driveLine(60, 90, 150);
    applyStimulus(1'b1, 151, 60, 12'($urandom));
    applyStimulus(1'b1, 152, 60, 12'($urandom));
    driveLine(60, 0, 300);

    xpos = 12'd400;
    ypos = 12'd20;
    applyStimulus(1'b0, 799, 599, 12'($urandom));
    applyStimulus(1'b1, 0, 600, 12'($urandom));
    driveLine(60, 0, 200);
    latchPos(400, 20);
    driveLine(60, 380, 560);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
